// File: rtl/map_ss_seq.sv
// -----------------------------------------------------------------------------
// map_ss_seq
//
// Save-state sequencer for mapper cores. Walks a window of the mapper
// save-state register space to either stream a snapshot out to the host
// (SAVE, mapper -> host) or stream one back in (LOAD, host -> mapper).
// Before any transfer the mapper-index register is read and compared with the
// index the host expects; a mismatch sets a sticky id_err and the command
// completes without touching the window.
//
// Parameters
//   RD_WAIT   cycles ss_addr is held before ss_rdat is sampled (>= 1)
//   WR_HOLD   cycles ss_we is held high per written register (>= 1)
//   IDX_ADDR  ss_addr of the mapper-index register
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   start      1-cycle command strobe, only honoured while idle
//   mode       0 = SAVE, 1 = LOAD (sampled with start)
//   base       first ss_addr of the window (sampled with start)
//   count      registers to transfer, 0 means 256 (sampled with start)
//   exp_idx    expected mapper index (sampled with start)
//   abort      terminate the current command
//   busy       command in progress
//   done       1-cycle pulse on normal completion
//   aborted    1-cycle pulse on abort exit
//   id_err     sticky index mismatch flag, cleared by the next accepted start
//   ss_act     save-state access active
//   ss_we      save-state register write strobe
//   ss_addr    save-state register address
//   ss_wdat    write data to the mapper
//   ss_rdat    read data from the mapper
//   out_valid  SAVE stream byte valid
//   out_data   SAVE stream byte
//   out_ready  host accepts the SAVE byte
//   in_valid   LOAD stream byte valid
//   in_data    LOAD stream byte
//   in_ready   block accepts the LOAD byte
// -----------------------------------------------------------------------------
module map_ss_seq #(
    parameter int         RD_WAIT  = 2,
    parameter int         WR_HOLD  = 2,
    parameter logic [7:0] IDX_ADDR = 8'd127
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mode,
    input  logic [7:0] base,
    input  logic [7:0] count,
    input  logic [7:0] exp_idx,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic       id_err,
    output logic       ss_act,
    output logic       ss_we,
    output logic [7:0] ss_addr,
    output logic [7:0] ss_wdat,
    input  logic [7:0] ss_rdat,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_IDCHK   = 3'd1,
        S_RD_WAIT = 3'd2,
        S_RD_PUSH = 3'd3,
        S_WR_PULL = 3'd4,
        S_WR_HOLD = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    // The wait counter serves both the read settle time and the write hold.
    // WR_HOLD needs one extra count for the trailing cycle in which ss_we is
    // already low but address/data are still held for the mapper.
    localparam int MAX_WAIT = (RD_WAIT > WR_HOLD) ? RD_WAIT : WR_HOLD;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WE_CYCLES = CNT_W'(WR_HOLD);

    state_t           state_reg;
    state_t           state_next;

    logic             mode_reg;
    logic [7:0]       base_reg;
    logic [7:0]       exp_idx_reg;
    logic [8:0]       remaining_reg;
    logic [CNT_W-1:0] wait_cnt_reg;
    logic [7:0]       ss_addr_reg;
    logic [7:0]       ss_wdat_reg;
    logic [7:0]       out_data_reg;
    logic             id_err_reg;
    logic             aborted_reg;

    logic             start_ok;
    logic             abort_ok;
    logic             rd_last;
    logic             wr_last;
    logic             last_reg;
    logic             id_ok;
    logic             counting;

    // ------------------------------------------------------------------
    // Shared decode
    // ------------------------------------------------------------------
    always_comb begin
        start_ok = (state_reg == S_IDLE) && start;
        abort_ok = (state_reg != S_IDLE) && abort;
        rd_last  = (wait_cnt_reg == RD_LAST);
        wr_last  = (wait_cnt_reg == WE_CYCLES);
        last_reg = (remaining_reg == 9'd1);
        id_ok    = (ss_rdat == exp_idx_reg);
        counting = (state_reg == S_IDCHK) || (state_reg == S_RD_WAIT) ||
                   (state_reg == S_WR_HOLD);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. Abort overrides everything outside IDLE, so a
    // start and abort arriving together while idle still starts a command.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        if (abort_ok) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_next = S_IDCHK;
                    end
                end
                S_IDCHK: begin
                    if (rd_last) begin
                        if (!id_ok) begin
                            state_next = S_DONE;
                        end else if (mode_reg) begin
                            state_next = S_WR_PULL;
                        end else begin
                            state_next = S_RD_WAIT;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (rd_last) begin
                        state_next = S_RD_PUSH;
                    end
                end
                S_RD_PUSH: begin
                    if (out_ready) begin
                        state_next = last_reg ? S_DONE : S_RD_WAIT;
                    end
                end
                S_WR_PULL: begin
                    if (in_valid) begin
                        state_next = S_WR_HOLD;
                    end
                end
                S_WR_HOLD: begin
                    if (wr_last) begin
                        state_next = last_reg ? S_DONE : S_WR_PULL;
                    end
                end
                S_DONE: begin
                    state_next = S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs. busy and ss_act are already low in DONE so they fall
    // on the same edge that raises done.
    // ------------------------------------------------------------------
    always_comb begin
        busy      = 1'b0;
        ss_act    = 1'b0;
        ss_we     = 1'b0;
        out_valid = 1'b0;
        in_ready  = 1'b0;
        done      = 1'b0;
        case (state_reg)
            S_IDCHK, S_RD_WAIT, S_RD_PUSH, S_WR_PULL: begin
                busy   = 1'b1;
                ss_act = 1'b1;
                if (state_reg == S_RD_PUSH) begin
                    out_valid = 1'b1;
                end
                if (state_reg == S_WR_PULL) begin
                    in_ready = 1'b1;
                end
            end
            S_WR_HOLD: begin
                busy   = 1'b1;
                ss_act = 1'b1;
                // High for the first WR_HOLD cycles, low for the trailing one.
                ss_we  = (wait_cnt_reg < WE_CYCLES);
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign ss_addr  = ss_addr_reg;
    assign ss_wdat  = ss_wdat_reg;
    assign out_data = out_data_reg;
    assign id_err   = id_err_reg;
    assign aborted  = aborted_reg;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg      <= 1'b0;
            base_reg      <= 8'd0;
            exp_idx_reg   <= 8'd0;
            remaining_reg <= 9'd0;
            wait_cnt_reg  <= '0;
            ss_addr_reg   <= 8'd0;
            ss_wdat_reg   <= 8'd0;
            out_data_reg  <= 8'd0;
            id_err_reg    <= 1'b0;
            aborted_reg   <= 1'b0;
        end else begin
            aborted_reg <= abort_ok;

            // Every timed state is entered with the counter at zero.
            if (counting && (state_next == state_reg)) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end else begin
                wait_cnt_reg <= '0;
            end

            if (!abort_ok) begin
                case (state_reg)
                    S_IDLE: begin
                        if (start_ok) begin
                            mode_reg      <= mode;
                            base_reg      <= base;
                            exp_idx_reg   <= exp_idx;
                            // count==0 encodes a full 256-register window.
                            remaining_reg <= {(count == 8'd0), count};
                            id_err_reg    <= 1'b0;
                            ss_addr_reg   <= IDX_ADDR;
                        end
                    end
                    S_IDCHK: begin
                        if (rd_last) begin
                            if (id_ok) begin
                                ss_addr_reg <= base_reg;
                            end else begin
                                id_err_reg <= 1'b1;
                            end
                        end
                    end
                    S_RD_WAIT: begin
                        if (rd_last) begin
                            out_data_reg <= ss_rdat;
                        end
                    end
                    S_RD_PUSH: begin
                        if (out_ready) begin
                            remaining_reg <= remaining_reg - 9'd1;
                            ss_addr_reg   <= ss_addr_reg + 8'd1;
                        end
                    end
                    S_WR_PULL: begin
                        if (in_valid) begin
                            ss_wdat_reg <= in_data;
                        end
                    end
                    S_WR_HOLD: begin
                        if (wr_last) begin
                            remaining_reg <= remaining_reg - 9'd1;
                            ss_addr_reg   <= ss_addr_reg + 8'd1;
                        end
                    end
                    default: begin
                        mode_reg <= mode_reg;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_map_ss_seq.sv
// -----------------------------------------------------------------------------
// tb_map_ss_seq
//
// Directed bench for map_ss_seq. A 256-byte array models the mapper
// save-state space (combinational read, write on ss_we). A negedge monitor
// collects SAVE stream bytes, write pulses and done/aborted pulses; each
// command's results are compared against hand-computed values.
// -----------------------------------------------------------------------------
module tb_map_ss_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       mode;
    logic [7:0] base;
    logic [7:0] count;
    logic [7:0] exp_idx;
    logic       abort;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       id_err;
    logic       ss_act;
    logic       ss_we;
    logic [7:0] ss_addr;
    logic [7:0] ss_wdat;
    logic [7:0] ss_rdat;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    always #5 clk = ~clk;

    map_ss_seq #(
        .RD_WAIT (2),
        .WR_HOLD (2),
        .IDX_ADDR(8'd127)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .base     (base),
        .count    (count),
        .exp_idx  (exp_idx),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .id_err   (id_err),
        .ss_act   (ss_act),
        .ss_we    (ss_we),
        .ss_addr  (ss_addr),
        .ss_wdat  (ss_wdat),
        .ss_rdat  (ss_rdat),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready)
    );

    // ---------------- mapper register model ----------------
    logic [7:0] mem [256];
    logic       fill_en = 1'b0;
    logic       poke_en = 1'b0;
    logic [7:0] poke_a  = 8'd0;
    logic [7:0] poke_d  = 8'd0;

    assign ss_rdat = mem[ss_addr];

    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 3);
        end else if (ss_we) begin
            mem[ss_addr] <= ss_wdat;
        end else if (poke_en) begin
            mem[poke_a] <= poke_d;
        end
    end

    // ---------------- monitor ----------------
    logic [7:0] out_q     [$];
    logic [7:0] oaddr_q   [$];
    logic [7:0] we_addr_q [$];
    logic [7:0] we_dat_q  [$];
    int         we_w_q    [$];
    int         we_len    = 0;
    logic [7:0] cur_a     = 8'd0;
    logic [7:0] cur_d     = 8'd0;
    int         we_bad    = 0;
    int         stall_bad = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_od   = 8'd0;
    int         done_cnt  = 0;
    int         ab_cnt    = 0;

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            out_q.push_back(out_data);
            oaddr_q.push_back(ss_addr);
        end
        if (prev_stall && out_valid && (out_data !== prev_od)) stall_bad <= stall_bad + 1;
        prev_stall <= out_valid && !out_ready;
        prev_od    <= out_data;
        if (ss_we) begin
            if (we_len == 0) begin
                we_addr_q.push_back(ss_addr);
                we_dat_q.push_back(ss_wdat);
                cur_a <= ss_addr;
                cur_d <= ss_wdat;
            end else if ((ss_addr !== cur_a) || (ss_wdat !== cur_d)) begin
                we_bad <= we_bad + 1;
            end
            we_len <= we_len + 1;
        end else if (we_len != 0) begin
            we_w_q.push_back(we_len);
            // address/data must still be held one cycle after ss_we falls
            if (ss_act && ((ss_addr !== cur_a) || (ss_wdat !== cur_d))) we_bad <= we_bad + 1;
            we_len <= 0;
        end
        if (done)    done_cnt <= done_cnt + 1;
        if (aborted) ab_cnt   <= ab_cnt + 1;
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    logic [7:0] in_bytes [$];
    int  o0, wa0, ww0, d0, a0, sb0, wb0;
    int  cyc;
    bit  fin;
    bit  busy0;
    int  ncmd = 0;

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        poke_a = a; poke_d = d; poke_en = 1'b1;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issues one command and drives both streams until done/aborted or the
    // cycle budget expires. abort_rise>0 raises abort on the cycle that
    // write pulse number abort_rise begins.
    task automatic run_cmd(input logic m, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] e, input bit stall, input int abort_rise,
                           input int budget);
        int  idx   = 0;
        int  rises = 0;
        bit  hs;
        bit  rose;
        bit  prev_we = 1'b0;
        o0 = out_q.size(); wa0 = we_addr_q.size(); ww0 = we_w_q.size();
        d0 = done_cnt; a0 = ab_cnt; sb0 = stall_bad; wb0 = we_bad;
        @(posedge clk); #1;
        start = 1'b1; mode = m; base = b; count = c; exp_idx = e;
        @(posedge clk); #1;
        start = 1'b0;
        busy0 = busy;
        cyc = 0; fin = 1'b0;
        in_valid  = (idx < in_bytes.size());
        in_data   = (idx < in_bytes.size()) ? in_bytes[idx] : 8'd0;
        out_ready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
        while (cyc < budget && !fin) begin
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            abort = 1'b0;
            if (hs) idx++;
            rose = ss_we && !prev_we;
            prev_we = ss_we;
            if (rose) rises++;
            if (done || aborted) fin = 1'b1;
            else if (abort_rise != 0 && rose && rises == abort_rise) abort = 1'b1;
            in_valid  = !fin && (idx < in_bytes.size());
            in_data   = (idx < in_bytes.size()) ? in_bytes[idx] : 8'd0;
            out_ready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
        end
        check_eq("cmd_finished", 32'(fin), 32'd1);
        in_valid = 1'b0;
        abort    = 1'b0;
        ncmd++;
        $display("cmd %0d mode=%0d base=%02h count=%0d bytes_out=%0d writes=%0d cycles=%0d",
                 ncmd, m, b, c, out_q.size() - o0, we_addr_q.size() - wa0, cyc);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; base = 8'd0; count = 8'd0;
        exp_idx = 8'd0; abort = 1'b0; out_ready = 1'b0; in_valid = 1'b0; in_data = 8'd0;
        fill_en = 1'b1;
        wait_cycles(3);
        fill_en = 1'b0;
        check_eq("rst_ctrl", 32'({busy, done, aborted, id_err, ss_act, ss_we, out_valid, in_ready}), 32'd0);
        check_eq("rst_addr", 32'(ss_addr), 32'd0);
        check_eq("rst_data", 32'({out_data, ss_wdat}), 32'd0);
        rst_n = 1'b1;
        poke(8'd127, 8'h12);

        // 1: SAVE base 0 count 15, regs = i*3
        run_cmd(1'b0, 8'h00, 8'd15, 8'h12, 1'b0, 0, 200);
        check_eq("save_busy_p0", 32'(busy0), 32'd1);
        check_eq("save_cycles", 32'(cyc), 32'd47);
        check_eq("save_done_busy", 32'({busy, ss_act}), 32'd0);
        wait_cycles(3);
        check_eq("save_done_cnt", 32'(done_cnt - d0), 32'd1);
        check_eq("save_nbytes", 32'(out_q.size() - o0), 32'd15);
        check_eq("save_nwrites", 32'(we_addr_q.size() - wa0), 32'd0);
        check_eq("save_id_err", 32'(id_err), 32'd0);
        for (int i = 0; i < 15 && (o0 + i) < out_q.size(); i++) begin
            check_eq("save_byte", 32'(out_q[o0 + i]), 32'(i * 3));
            check_eq("save_addr", 32'(oaddr_q[o0 + i]), 32'(i));
        end

        // 2: LOAD base 0 count 4
        in_bytes = '{8'hA5, 8'h5A, 8'hFF, 8'h00};
        run_cmd(1'b1, 8'h00, 8'd4, 8'h12, 1'b0, 0, 200);
        check_eq("load_cycles", 32'(cyc), 32'd18);
        wait_cycles(3);
        check_eq("load_done_cnt", 32'(done_cnt - d0), 32'd1);
        check_eq("load_nwrites", 32'(we_addr_q.size() - wa0), 32'd4);
        check_eq("load_nwidths", 32'(we_w_q.size() - ww0), 32'd4);
        check_eq("load_hold_stable", 32'(we_bad - wb0), 32'd0);
        check_eq("load_nbytes_out", 32'(out_q.size() - o0), 32'd0);
        for (int i = 0; i < 4 && (wa0 + i) < we_addr_q.size() && (ww0 + i) < we_w_q.size(); i++) begin
            check_eq("load_we_addr", 32'(we_addr_q[wa0 + i]), 32'(i));
            check_eq("load_we_data", 32'(we_dat_q[wa0 + i]), 32'(in_bytes[i]));
            check_eq("load_we_width", 32'(we_w_q[ww0 + i]), 32'd2);
            check_eq("load_mem", 32'(mem[i]), 32'(in_bytes[i]));
        end

        // 3: index mismatch on a LOAD: no transfer at all
        poke(8'd127, 8'h26);
        in_bytes = '{8'h77, 8'h88};
        run_cmd(1'b1, 8'h00, 8'd2, 8'h25, 1'b0, 0, 50);
        check_eq("idchk_cycles", 32'(cyc), 32'd2);
        check_eq("idchk_id_err", 32'(id_err), 32'd1);
        wait_cycles(3);
        check_eq("idchk_done_cnt", 32'(done_cnt - d0), 32'd1);
        check_eq("idchk_nwrites", 32'(we_addr_q.size() - wa0), 32'd0);
        check_eq("idchk_nbytes", 32'(out_q.size() - o0), 32'd0);
        check_eq("idchk_sticky", 32'(id_err), 32'd1);
        check_eq("idchk_mem0", 32'(mem[0]), 32'hA5);

        // 4: SAVE across the 255->0 wrap with random stalls
        poke(8'd127, 8'h12);
        poke(8'hFE, 8'hE1);
        poke(8'hFF, 8'hE2);
        run_cmd(1'b0, 8'hFE, 8'd3, 8'h12, 1'b1, 0, 400);
        check_eq("wrap_id_err_clr", 32'(id_err), 32'd0);
        wait_cycles(3);
        check_eq("wrap_done_cnt", 32'(done_cnt - d0), 32'd1);
        check_eq("wrap_nbytes", 32'(out_q.size() - o0), 32'd3);
        check_eq("wrap_stable", 32'(stall_bad - sb0), 32'd0);
        if (out_q.size() - o0 == 3) begin
            check_eq("wrap_b0", 32'({oaddr_q[o0], out_q[o0]}), 32'hFEE1);
            check_eq("wrap_b1", 32'({oaddr_q[o0 + 1], out_q[o0 + 1]}), 32'hFFE2);
            check_eq("wrap_b2", 32'({oaddr_q[o0 + 2], out_q[o0 + 2]}), 32'h00A5);
        end

        // 5: count=0 -> full 256-register window
        run_cmd(1'b0, 8'h40, 8'd0, 8'h12, 1'b0, 0, 1000);
        check_eq("full_cycles", 32'(cyc), 32'd770);
        check_eq("full_addr_end", 32'(ss_addr), 32'h40);
        wait_cycles(3);
        check_eq("full_done_cnt", 32'(done_cnt - d0), 32'd1);
        check_eq("full_nbytes", 32'(out_q.size() - o0), 32'd256);
        begin
            int nbad = 0;
            logic [7:0] a;
            for (int j = 0; j < 256 && (o0 + j) < out_q.size(); j++) begin
                a = 8'(8'h40 + j);
                if (oaddr_q[o0 + j] !== a || out_q[o0 + j] !== mem[a]) nbad++;
            end
            check_eq("full_stream", 32'(nbad), 32'd0);
        end

        // 6: abort during the second write hold
        in_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_cmd(1'b1, 8'h10, 8'd4, 8'h12, 1'b0, 2, 200);
        check_eq("abort_pulse", 32'(aborted), 32'd1);
        check_eq("abort_outs", 32'({ss_we, ss_act, busy, in_ready, out_valid, done}), 32'd0);
        wait_cycles(1);
        check_eq("abort_pulse_end", 32'(aborted), 32'd0);
        wait_cycles(3);
        check_eq("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check_eq("abort_cnt", 32'(ab_cnt - a0), 32'd1);
        check_eq("abort_nwrites", 32'(we_w_q.size() - ww0), 32'd2);
        if (we_w_q.size() - ww0 == 2) begin
            check_eq("abort_w1", 32'(we_w_q[ww0]), 32'd2);
            check_eq("abort_w2_cut", 32'(we_w_q[ww0 + 1]), 32'd1);
            check_eq("abort_addr2", 32'(we_addr_q[wa0 + 1]), 32'h11);
        end

        // 7: abort while idle is ignored
        abort = 1'b1;
        wait_cycles(1);
        abort = 1'b0;
        check_eq("idle_abort", 32'({aborted, busy, ss_act}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
